// File: rtl/aes_inv_cipher_top.sv
// AES-128 iterative inverse cipher: one round per clock, with the key schedule expanded on chip.
// Optional build macro AES_INV_KEY_CACHE_EN skips key expansion when the same key is loaded again.
module aes_inv_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} state_e;

  localparam logic [0:255][7:0] FWD_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse MixColumns constants, built from doubling chains: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Byte i of a block sits at bits [127-8i -: 8]; row r, column c is byte 4c+r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
      o[119-32*c -: 8] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
      o[111-32*c -: 8] = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
      o[103-32*c -: 8] = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w3 = rk[31:0];
    t  = {FWD_SBOX[w3[23:16]] ^ rc, FWD_SBOX[w3[15:8]], FWD_SBOX[w3[7:0]], FWD_SBOX[w3[31:24]]};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    return {w0, w1, w2, w2 ^ w3};
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] kexp_q, kexp_d;
  logic [127:0] text_out_q, text_out_d;
  logic         done_q, done_d;
  logic [127:0] rk_q [0:10];
  logic         rk_we;
  logic [3:0]   rk_waddr;
  logic [127:0] rk_wdata;
  logic [127:0] rk_sel, kexp_next, round_core;
  logic         hit;

`ifdef AES_INV_KEY_CACHE_EN
  logic [127:0] cache_key_q;
  logic         cache_vld_q;
  logic         cache_set;

  // The cache tags the schedule only once rk10 has been written.
  assign cache_set = (state_q == KEXP) && (cnt_q == 4'd10);
  assign hit       = cache_vld_q && (key == cache_key_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
    end else if (cache_set) begin
      cache_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cache_set) begin
      cache_key_q <= rk_q[0];
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    rk_sel = '0;
    if (cnt_q <= 4'd10) begin
      rk_sel = rk_q[cnt_q];
    end
  end

  assign kexp_next  = key_expand(kexp_q, rcon(cnt_q));
  assign round_core = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_sel;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    st_d       = st_q;
    kexp_d     = kexp_q;
    text_out_d = text_out_q;
    done_d     = 1'b0;
    rk_we      = 1'b0;
    rk_waddr   = cnt_q;
    rk_wdata   = kexp_next;
    case (state_q)
      IDLE: begin
        if (ld) begin
          st_d = text_in;
          if (hit) begin
            state_d = INIT;
          end else begin
            kexp_d   = key;
            rk_we    = 1'b1;
            rk_waddr = 4'd0;
            rk_wdata = key;
            cnt_d    = 4'd1;
            state_d  = KEXP;
          end
        end
      end
      KEXP: begin
        kexp_d = kexp_next;
        rk_we  = 1'b1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd10) begin
          state_d = INIT;
        end
      end
      INIT: begin
        st_d    = st_q ^ rk_q[10];
        cnt_d   = 4'd9;
        state_d = ROUND;
      end
      ROUND: begin
        st_d  = inv_mix_columns(round_core);
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        text_out_d = round_core;
        done_d     = 1'b1;
        cnt_d      = 4'd0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      text_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      text_out_q <= text_out_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    st_q   <= st_d;
    kexp_q <= kexp_d;
    if (rk_we) begin
      rk_q[rk_waddr] <= rk_wdata;
    end
  end

  assign text_out = text_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Randomized self-checking bench for aes_inv_cipher_top against a FIPS-197 decryption model.
// Honours AES_INV_KEY_CACHE_EN for the expected latency of repeated keys.
module tb_aes_inv_cipher_top;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic [127:0] text_out;
  logic         done;

  aes_inv_cipher_top dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .key      (key),
    .text_in  (text_in),
    .text_out (text_out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [7:0]   sb  [0:255];
  logic [7:0]   isb [0:255];
  logic [127:0] m_cache_key;
  bit           m_cache_vld;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] v, inv, s;
    for (int x = 0; x < 256; x++) begin
      v   = 8'(x);
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, v);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x]  = s;
      isb[s] = v;
    end
  endtask

  function automatic logic [127:0] model_decrypt(input logic [127:0] k, input logic [127:0] ct);
    logic [7:0]   w   [0:175];
    logic [7:0]   s   [0:15];
    logic [7:0]   t   [0:15];
    logic [7:0]   tmp [0:3];
    logic [7:0]   mc  [0:3];
    logic [7:0]   rc, b, acc;
    logic [127:0] o;
    mc = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        b      = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[b];
        rc     = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[160+i];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*((c + r) % 4)] = s[r + 4*c];
      for (int i = 0; i < 16; i++) s[i] = isb[t[i]] ^ w[16*rnd + i];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(mc[(j - r + 4) % 4], s[4*c + j]);
            t[4*c + r] = acc;
          end
        end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Expected latency for a load of key k; also records the schedule that load leaves behind.
  function automatic int model_start(input logic [127:0] k);
    int lat;
    lat = 21;
`ifdef AES_INV_KEY_CACHE_EN
    if (m_cache_vld && k == m_cache_key) lat = 11;
    m_cache_key = k;
    m_cache_vld = 1'b1;
`endif
    return lat;
  endfunction

  // Loads one block and waits for done; inj > 0 re-pulses ld with junk inputs at that cycle.
  task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] exp_pt, input int inj);
    int           lat, n;
    logic [127:0] prev;
    bit           moved;
    lat     = model_start(k);
    prev    = text_out;
    moved   = 1'b0;
    key     = k;
    text_in = ct;
    ld      = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    n  = 0;
    while (done !== 1'b1 && n < 40) begin
      key     = rand128();
      text_in = rand128();
      ld      = (inj > 0 && n == inj - 1);
      if (text_out !== prev) moved = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    ld = 1'b0;
    check({tag, "_lat"}, 128'(n), 128'(lat));
    check({tag, "_pt"}, text_out, exp_pt);
    check({tag, "_hold"}, 128'(moved), 128'(0));
  endtask

  task automatic check_done_width(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_width"}, 128'(done), 128'(0));
  endtask

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C3 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] P3 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  initial begin
    logic [127:0] k, ct, ka, cb;
    bit           seen;
    int           lat;
    n_chk       = 0;
    n_fail      = 0;
    m_cache_vld = 1'b0;
    m_cache_key = '0;
    build_tables();

    // Reset with ld held high: reset must win and nothing may start.
    rst     = 1'b1;
    ld      = 1'b1;
    key     = K1;
    text_in = C1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    ld  = 1'b0;
    check("rst_text_out", text_out, 128'h0);
    check("rst_done", 128'(done), 128'(0));
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    check("rst_prio_nodone", 128'(seen), 128'(0));

    run_op("kat1", K1, C1, P1, 0);
    check_done_width("kat1");
    run_op("kat2", K2, C2, P2, 0);
    run_op("kat3_repeat_key", K2, C3, P3, 0);
    check_done_width("kat3");

    run_op("ld_ignored", K1, C1, P1, 5);
    repeat (5) @(posedge clk);
    #1;
    check("idle_hold", text_out, P1);

    k  = rand128();
    ct = rand128();
    run_op("rand_pre_abort", k, ct, model_decrypt(k, ct), 0);

    // Abort a K1 operation at cycle 15; the cache must not survive the reset.
    lat     = model_start(K1);
    key     = K1;
    text_in = rand128();
    ld      = 1'b1;
    @(posedge clk); #1;
    ld   = 1'b0;
    seen = 1'b0;
    for (int i = 1; i < 15; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    m_cache_vld = 1'b0;
    check("abort_text_out", text_out, 128'h0);
    check("abort_done", 128'(done), 128'(0));
    repeat (30) begin
      @(posedge clk); #1;
      if (done !== 1'b0) seen = 1'b1;
    end
    check("abort_nodone", 128'(seen), 128'(0));
    run_op("kat1_after_abort", K1, C1, P1, 0);

    // Second load issued in the done cycle of the first, reusing the key.
    ka = rand128();
    ct = rand128();
    cb = rand128();
    run_op("b2b_first", ka, ct, model_decrypt(ka, ct), 0);
    run_op("b2b_second", ka, cb, model_decrypt(ka, cb), 0);
    check_done_width("b2b");

    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 0) k = rand128();
      ct = rand128();
      run_op($sformatf("rand%0d", i), k, ct, model_decrypt(k, ct), 0);
    end
    check_done_width("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
